rr_op_sequencer: RTL and testbench

RR_OP_SEQUENCER -- requirements
Module: rr_op_sequencer

---
 rtl/rr_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rr_op_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_op_sequencer.sv
// Control-step sequencer for register-register instructions (fetch T0..T2, execute T3..T6).
// Defining SEQ_SINGLE_STEP_EN adds a step input that gates advancement out of T0..T6.
module rr_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 6
) (
  input  logic                w_clock,
  input  logic                w_clear,
  input  logic                start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         ir_in,
  output logic                s_PC,
  output logic                s_Zlow,
  output logic                s_Zhigh,
  output logic                s_MDR,
  output logic [NUM_REGS-1:0] s_R,
  output logic [NUM_REGS-1:0] e_R,
  output logic                e_MAR,
  output logic                e_Z,
  output logic                e_PC,
  output logic                e_MDR,
  output logic                e_IR,
  output logic                e_Y,
  output logic                e_HI,
  output logic                e_LO,
  output logic                e_alu,
  output logic                w_IncPC,
  output logic                w_read,
  output logic [OPC_W-1:0]    opcode,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  typedef struct packed {
    logic                s_pc, s_zlow, s_zhigh, s_mdr;
    logic [NUM_REGS-1:0] s_r, e_r;
    logic                e_mar, e_z, e_pc, e_mdr, e_ir, e_y, e_hi, e_lo, e_alu;
    logic                w_incpc, w_read, busy, done, err;
  } ctrl_t;

  state_t state, state_n;
  ctrl_t  ctrl;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unary, muldiv, illegal, advance;
  logic       unused_ir;

  assign op = ir_in[31:27];
  assign ra = ir_in[26:23];
  assign rb = ir_in[22:19];
  assign rc = ir_in[18:15];
  assign unused_ir = ^ir_in[14:0];

  assign unary  = (op == 5'd4) || (op == 5'd12);
  assign muldiv = (op == 5'd5) || (op == 5'd6);

  // mul/div write HI/LO, so Ra is not a used field for them; unary ops have no Rc.
  assign illegal = (op > 5'd12)
                || (32'(rb) >= NUM_REGS)
                || (!unary  && (32'(rc) >= NUM_REGS))
                || (!muldiv && (32'(ra) >= NUM_REGS));

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  always_comb begin
    // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = T0;
      T0:      state_n = T1;
      T1:      state_n = T2;
      // A bad unary instruction still visits T3 so the fault is flagged there.
      T2:      state_n = (unary && !illegal) ? T4 : T3;
      T3:      state_n = illegal ? IDLE : T4;
      T4:      state_n = T5;
      T5:      state_n = muldiv ? T6 : IDLE;
      T6:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !advance) state_n = state;
  end

  // Outputs are registered: computed for the state being entered.
  function automatic ctrl_t decode(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      T0: begin c.s_pc = 1'b1; c.e_mar = 1'b1; c.w_incpc = 1'b1; c.e_z = 1'b1; end
      T1: begin c.s_zlow = 1'b1; c.e_pc = 1'b1; c.w_read = 1'b1; c.e_mdr = 1'b1; end
      T2: begin c.s_mdr = 1'b1; c.e_ir = 1'b1; end
      T3: begin
        if (illegal) c.err = 1'b1;
        else begin c.s_r = one_hot(rb); c.e_y = 1'b1; end
      end
      T4: begin
        c.s_r   = unary ? one_hot(rb) : one_hot(rc);
        c.e_z   = 1'b1;
        c.e_alu = 1'b1;
      end
      T5: begin
        c.s_zlow = 1'b1;
        if (muldiv) c.e_lo = 1'b1;
        else begin c.e_r = one_hot(ra); c.done = 1'b1; end
      end
      T6: begin c.s_zhigh = 1'b1; c.e_hi = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    c.busy = (st != IDLE);
    return c;
  endfunction

  always_ff @(posedge w_clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (w_clear) begin
      state <= IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_n;
      ctrl  <= decode(state_n);
    end
  end

  assign s_PC    = ctrl.s_pc;
  assign s_Zlow  = ctrl.s_zlow;
  assign s_Zhigh = ctrl.s_zhigh;
  assign s_MDR   = ctrl.s_mdr;
  assign s_R     = ctrl.s_r;
  assign e_R     = ctrl.e_r;
  assign e_MAR   = ctrl.e_mar;
  assign e_Z     = ctrl.e_z;
  assign e_PC    = ctrl.e_pc;
  assign e_MDR   = ctrl.e_mdr;
  assign e_IR    = ctrl.e_ir;
  assign e_Y     = ctrl.e_y;
  assign e_HI    = ctrl.e_hi;
  assign e_LO    = ctrl.e_lo;
  assign e_alu   = ctrl.e_alu;
  assign w_IncPC = ctrl.w_incpc;
  assign w_read  = ctrl.w_read;
  assign busy    = ctrl.busy;
  assign done    = ctrl.done;
  assign err     = ctrl.err;

  // Opcode follows ir_in directly, forced to zero while idle.
  assign opcode = ctrl.busy ? OPC_W'(op) : '0;

endmodule

// File: tb/tb_rr_op_sequencer.sv
// Scoreboard bench for rr_op_sequencer: expected control steps are queued per instruction
// and popped one per clock; single-step checks are built when SEQ_SINGLE_STEP_EN is defined.
module tb_rr_op_sequencer;

  localparam int NR = 8;

  localparam logic [17:0] K_SPC  = 18'(1) << 17;
  localparam logic [17:0] K_SZL  = 18'(1) << 16;
  localparam logic [17:0] K_SZH  = 18'(1) << 15;
  localparam logic [17:0] K_SMDR = 18'(1) << 14;
  localparam logic [17:0] K_EMAR = 18'(1) << 13;
  localparam logic [17:0] K_EZ   = 18'(1) << 12;
  localparam logic [17:0] K_EPC  = 18'(1) << 11;
  localparam logic [17:0] K_EMDR = 18'(1) << 10;
  localparam logic [17:0] K_EIR  = 18'(1) << 9;
  localparam logic [17:0] K_EY   = 18'(1) << 8;
  localparam logic [17:0] K_EHI  = 18'(1) << 7;
  localparam logic [17:0] K_ELO  = 18'(1) << 6;
  localparam logic [17:0] K_ALU  = 18'(1) << 5;
  localparam logic [17:0] K_INC  = 18'(1) << 4;
  localparam logic [17:0] K_RD   = 18'(1) << 3;
  localparam logic [17:0] K_BUSY = 18'(1) << 2;
  localparam logic [17:0] K_DONE = 18'(1) << 1;
  localparam logic [17:0] K_ERR  = 18'(1) << 0;

  logic          w_clock = 1'b0;
  logic          w_clear, start, step;
  logic [31:0]   ir_in;
  logic          s_PC, s_Zlow, s_Zhigh, s_MDR;
  logic [NR-1:0] s_R, e_R;
  logic          e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu, w_IncPC, w_read;
  logic [5:0]    opcode;
  logic          busy, done, err;
  logic [17:0]   obs_ctl;

  typedef struct {
    string         tag;
    logic [17:0]   ctl;
    logic [NR-1:0] sr;
    logic [NR-1:0] er;
    logic [5:0]    opc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 w_clock = ~w_clock;

  rr_op_sequencer #(.NUM_REGS(NR), .OPC_W(6)) dut (
    .w_clock(w_clock), .w_clear(w_clear), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_in(ir_in),
    .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR),
    .s_R(s_R), .e_R(e_R),
    .e_MAR(e_MAR), .e_Z(e_Z), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR), .e_Y(e_Y),
    .e_HI(e_HI), .e_LO(e_LO), .e_alu(e_alu), .w_IncPC(w_IncPC), .w_read(w_read),
    .opcode(opcode), .busy(busy), .done(done), .err(err)
  );

  assign obs_ctl = {s_PC, s_Zlow, s_Zhigh, s_MDR, e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y,
                    e_HI, e_LO, e_alu, w_IncPC, w_read, busy, done, err};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input logic [3:0] idx);
    return NR'(1) << idx;
  endfunction

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  task automatic push(input string tag, input logic [17:0] ctl, input logic [NR-1:0] sr,
                      input logic [NR-1:0] er, input logic [5:0] opc);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.sr = sr; e.er = er; e.opc = opc;
    sb.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    check({e.tag, ".ctl"}, 64'(obs_ctl), 64'(e.ctl));
    check({e.tag, ".s_R"}, 64'(s_R), 64'(e.sr));
    check({e.tag, ".e_R"}, 64'(e_R), 64'(e.er));
    check({e.tag, ".opcode"}, 64'(opcode), 64'(e.opc));
  endtask

  // Expected control steps derived from the instruction fields, ending with one idle cycle.
  task automatic push_instr(input string name, input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [5:0] o;
    logic       un, md, bad;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    o  = {1'b0, op};
    un = (op == 5'd4) || (op == 5'd12);
    md = (op == 5'd5) || (op == 5'd6);
    bad = (op > 5'd12) || (rb >= NR) || (!un && rc >= NR) || (!md && ra >= NR);
    push({name, ".T0"}, K_SPC | K_EMAR | K_INC | K_EZ | K_BUSY, '0, '0, o);
    push({name, ".T1"}, K_SZL | K_EPC | K_RD | K_EMDR | K_BUSY, '0, '0, o);
    push({name, ".T2"}, K_SMDR | K_EIR | K_BUSY, '0, '0, o);
    if (bad) begin
      push({name, ".T3err"}, K_ERR | K_BUSY, '0, '0, o);
    end else begin
      if (!un) push({name, ".T3"}, K_EY | K_BUSY, oh(rb), '0, o);
      push({name, ".T4"}, K_EZ | K_ALU | K_BUSY, un ? oh(rb) : oh(rc), '0, o);
      if (md) begin
        push({name, ".T5"}, K_SZL | K_ELO | K_BUSY, '0, '0, o);
        push({name, ".T6"}, K_SZH | K_EHI | K_DONE | K_BUSY, '0, '0, o);
      end else begin
        push({name, ".T5"}, K_SZL | K_DONE | K_BUSY, '0, oh(ra), o);
      end
    end
    push({name, ".idle"}, '0, '0, '0, '0);
  endtask

  task automatic launch(input logic [31:0] ir);
    ir_in = ir;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pops one expectation per cycle (first is T0) and checks the cycle index of done.
  task automatic run_sb(input string name, input int lat);
    int cyc = 1;
    int done_at = 0;
    exp_t e;
    while (sb.size() > 0 && cyc <= 20) begin
      e = sb.pop_front();
      cmp(e);
      if (done === 1'b1 && done_at == 0) done_at = cyc;
      tick();
      cyc++;
    end
    check({name, ".latency"}, 64'(done_at), 64'(lat));
  endtask

  task automatic do_instr(input string name, input logic [31:0] ir, input int lat);
    push_instr(name, ir);
    launch(ir);
    run_sb(name, lat);
  endtask

  task automatic expect_idle(input string name);
    push(name, '0, '0, '0, '0);
    cmp(sb.pop_front());
  endtask

  initial begin
    w_clear = 1'b1; start = 1'b0; step = 1'b1; ir_in = '0;
    tick(); tick();
    expect_idle("reset");
    start = 1'b1; ir_in = 32'h2891_8000;
    tick();
    expect_idle("reset_over_start");
    w_clear = 1'b0; start = 1'b0;
    tick();

    do_instr("mul",   32'h2891_8000, 7);
    do_instr("shra",  32'h5091_8000, 6);
    do_instr("not",   32'h2090_0000, 5);
    do_instr("opc13", 32'h6891_8000, 0);
    do_instr("div",   mk(6, 0, 7, 1), 7);
    do_instr("sub",   mk(1, 7, 0, 6), 6);
    do_instr("neg",   mk(12, 3, 7, 0), 5);
    do_instr("rc_oob", mk(0, 1, 2, 9), 0);

    // Clear in the middle of T4, then a normal instruction completes.
    launch(mk(0, 4, 5, 6));
    repeat (4) tick();
    check("mid.T4.ctl", 64'(obs_ctl), 64'(K_EZ | K_ALU | K_BUSY));
    check("mid.T4.s_R", 64'(s_R), 64'(oh(4'd6)));
    w_clear = 1'b1;
    tick();
    w_clear = 1'b0;
    expect_idle("mid.clear");
    do_instr("after_clear", mk(3, 2, 3, 4), 6);

    // start held through the done cycle: one idle cycle, then a new T0.
    push_instr("hold", 32'h5091_8000);
    ir_in = 32'h5091_8000;
    start = 1'b1;
    tick();
    run_sb("hold", 6);
    check("hold.restart.ctl", 64'(obs_ctl), 64'(K_SPC | K_EMAR | K_INC | K_EZ | K_BUSY));
    start = 1'b0;
    w_clear = 1'b1;
    tick();
    w_clear = 1'b0;
    expect_idle("hold.clear");

`ifdef SEQ_SINGLE_STEP_EN
    launch(mk(0, 1, 2, 3));
    tick(); tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("step.hold%0d.ctl", i), 64'(obs_ctl), 64'(K_SMDR | K_EIR | K_BUSY));
    end
    step = 1'b1;
    tick();
    check("step.T3.ctl", 64'(obs_ctl), 64'(K_EY | K_BUSY));
    check("step.T3.s_R", 64'(s_R), 64'(oh(4'd2)));
    w_clear = 1'b1;
    tick();
    w_clear = 1'b0;
    expect_idle("step.clear");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
